// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider: ratio limits,
// high-phase arithmetic and the core state encoding.
package clk_div_pkg;

  localparam int DIV_MIN       = 2;
  localparam int DIV_W_DEFAULT = 16;

  typedef logic [DIV_W_DEFAULT-1:0] div_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } core_state_t;

  // Odd ratios put the extra cycle in the high phase.
  function automatic logic [31:0] div_high(input logic [31:0] d);
    return d - (d >> 1);
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// Counter, phase compare and start/stop sequencing for the divider; the
// active ratio is supplied by the parent and only changes at period boundaries.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             Clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  output logic             clk_out,
  output logic             tick_rise,
  output logic             tick_fall,
  output logic             running,
  output logic             boundary
);

  core_state_t      state, state_next;
  logic [DIV_W-1:0] cnt, cnt_next, cnt_inc, high;
  logic             clk_next, at_end;

  assign high     = DIV_W'(div_high(32'(div)));
  assign cnt_inc  = cnt + DIV_W'(1);
  assign at_end   = (cnt == div - DIV_W'(1));
  assign running  = (state != IDLE);
  assign boundary = running && at_end;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    clk_next   = clk_out;
    case (state)
      IDLE: begin
        if (enable) begin
          state_next = RUN;
          cnt_next   = '0;
          clk_next   = 1'b1;
        end
      end
      RUN, DRAIN: begin
        // A stop request only takes effect once the period has been completed.
        if (at_end) begin
          cnt_next   = '0;
          state_next = enable ? RUN : IDLE;
          clk_next   = enable;
        end else begin
          cnt_next   = cnt_inc;
          clk_next   = (cnt_inc < high);
          state_next = enable ? RUN : DRAIN;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        clk_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk_in or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      clk_out   <= 1'b0;
      tick_rise <= 1'b0;
      tick_fall <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      clk_out   <= clk_next;
      tick_rise <= !clk_out && clk_next;
      tick_fall <= clk_out && !clk_next;
    end
  end

endmodule

// File: rtl/clk_div_prog.sv
// Run-time programmable clock divider: ratio handshake with a one-deep shadow
// register, range check, and boundary-synchronous ratio update around the core.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int REF_CLK_HZ  = 50_000_000,
  parameter int OUT_CLK_HZ  = 1_000_000,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = REF_CLK_HZ / OUT_CLK_HZ
) (
  input  logic             Clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic [DIV_W-1:0] div_val,
  input  logic             div_valid,
  output logic             div_ready,
  output logic             div_err,
  output logic             clk_out,
  output logic             tick_rise,
  output logic             tick_fall,
  output logic             running,
  output logic [DIV_W-1:0] div_active
);

  if (DEFAULT_DIV < DIV_MIN || longint'(DEFAULT_DIV) >= (longint'(1) << DIV_W)) begin : g_bad_default
    $error("clk_div_prog: DEFAULT_DIV out of range for DIV_W");
  end

  logic [DIV_W-1:0] shadow;
  logic             shadow_full, accept, val_ok, load, boundary;

  assign div_ready = !shadow_full;
  assign accept    = div_valid && div_ready;
  assign val_ok    = (div_val >= DIV_W'(DIV_MIN));
  // Idle dividers take the new ratio at once; running ones wait for the period end.
  assign load      = shadow_full && (boundary || !running);

  always_ff @(posedge Clk_in or negedge reset) begin
    if (!reset) begin
      shadow      <= '0;
      shadow_full <= 1'b0;
      div_active  <= DIV_W'(DEFAULT_DIV);
      div_err     <= 1'b0;
    end else begin
      div_err <= accept && !val_ok;
      if (load) begin
        div_active  <= shadow;
        shadow_full <= 1'b0;
      end
      if (accept && val_ok) begin
        shadow      <= div_val;
        shadow_full <= 1'b1;
      end
    end
  end

  clk_div_core #(
    .DIV_W(DIV_W)
  ) u_core (
    .Clk_in    (Clk_in),
    .reset     (reset),
    .enable    (enable),
    .div       (div_active),
    .clk_out   (clk_out),
    .tick_rise (tick_rise),
    .tick_fall (tick_fall),
    .running   (running),
    .boundary  (boundary)
  );

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: a period/position model checked every cycle,
// plus literal expectations on phase lengths, handshake timing and reset.
module tb_clk_div_prog;
  localparam int DIV_W = 16;
  localparam int DEF   = 50;

  logic             Clk_in = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic [DIV_W-1:0] div_val = '0;
  logic             div_valid = 1'b0;
  logic             div_ready, div_err, clk_out, tick_rise, tick_fall, running;
  logic [DIV_W-1:0] div_active;

  int checks = 0;
  int fails  = 0;

  clk_div_prog #(
    .REF_CLK_HZ(50_000_000),
    .OUT_CLK_HZ(1_000_000),
    .DIV_W     (DIV_W)
  ) dut (
    .Clk_in    (Clk_in),
    .reset     (reset),
    .enable    (enable),
    .div_val   (div_val),
    .div_valid (div_valid),
    .div_ready (div_ready),
    .div_err   (div_err),
    .clk_out   (clk_out),
    .tick_rise (tick_rise),
    .tick_fall (tick_fall),
    .running   (running),
    .div_active(div_active)
  );

  always #5 Clk_in = ~Clk_in;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: position within the current period, the ratio of that period and a
  // one-entry pending ratio; stop is decided by enable at the last cycle.
  int m_d = DEF, m_pos = 0, m_sh = 0;
  bit m_run = 0, m_sh_full = 0, m_err = 0, m_clk = 0, m_rise = 0, m_fall = 0;

  always @(posedge Clk_in or negedge reset) begin : model
    bit was_clk, last, load_now, take;
    if (!reset) begin
      m_d = DEF; m_pos = 0; m_run = 0; m_sh_full = 0;
      m_err = 0; m_clk = 0; m_rise = 0; m_fall = 0;
    end else begin
      was_clk  = m_clk;
      last     = m_run && (m_pos == m_d - 1);
      load_now = m_sh_full && (!m_run || last);
      take     = div_valid && !m_sh_full && (div_val >= 2);
      m_err    = div_valid && !m_sh_full && (div_val < 2);
      if (!m_run) begin
        if (enable) begin m_run = 1; m_pos = 0; end
      end else if (last) begin
        m_pos = 0;
        if (!enable) m_run = 0;
      end else begin
        m_pos++;
      end
      if (load_now) begin m_d = m_sh; m_sh_full = 0; end
      if (take) begin m_sh = int'(div_val); m_sh_full = 1; end
      m_clk  = m_run && (m_pos < (m_d + 1) / 2);
      m_rise = m_clk && !was_clk;
      m_fall = was_clk && !m_clk;
    end
  end

  always @(negedge Clk_in) begin
    checkOutput("model clk_out", clk_out, m_clk);
    checkOutput("model tick_rise", tick_rise, m_rise);
    checkOutput("model tick_fall", tick_fall, m_fall);
    checkOutput("model running", running, m_run);
    checkOutput("model div_active", div_active, m_d);
    checkOutput("model div_ready", div_ready, !m_sh_full);
    checkOutput("model div_err", div_err, m_err);
  end

  task automatic step(input int n);
    repeat (n) @(posedge Clk_in);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic vld, input logic [DIV_W-1:0] val);
    enable    = en;
    div_valid = vld;
    div_val   = val;
  endtask

  task automatic wait_rise();
    int n = 0;
    do begin step(1); n++; end while (!tick_rise && n < 200);
    if (!tick_rise) checkOutput("wait_rise timeout", 0, 1);
  endtask

  // Called on a tick_rise cycle; walks one full period.
  task automatic measure(output int high, output int period, output int fall_at);
    high = 0; period = 0; fall_at = -1;
    do begin
      if (clk_out) high++;
      if (tick_fall) fall_at = period;
      step(1);
      period++;
    end while (!tick_rise && period < 200);
    if (!tick_rise) checkOutput("measure timeout", 0, 1);
  endtask

  task automatic load_ratio(input logic [DIV_W-1:0] val);
    int n = 0;
    applyStimulus(enable, 1'b1, val);
    step(1);
    applyStimulus(enable, 1'b0, '0);
    while (div_active != val && n < 200) begin step(1); n++; end
    checkOutput("load_ratio applied", div_active, val);
  endtask

  initial begin : stim
    int h, p, f, n, ticks;
    bit ready_early;
    #2 reset = 1'b0;
    step(2);
    checkOutput("reset clk_out", clk_out, 0);
    checkOutput("reset running", running, 0);
    checkOutput("reset div_ready", div_ready, 1);
    checkOutput("reset div_active", div_active, DEF);

    // Default ratio 50
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, '0);
    step(1);
    checkOutput("start running", running, 1);
    checkOutput("start clk_out", clk_out, 1);
    checkOutput("start tick_rise", tick_rise, 1);
    measure(h, p, f);
    checkOutput("D50 high", h, 25);
    checkOutput("D50 period", p, 50);

    // Idle load of 7
    applyStimulus(1'b0, 1'b0, '0);
    n = 0;
    while (running && n < 100) begin step(1); n++; end
    checkOutput("stop reached idle", running, 0);
    applyStimulus(1'b0, 1'b1, 16'd7);
    step(1);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("idle capture ready", div_ready, 0);
    checkOutput("idle capture active", div_active, DEF);
    step(1);
    checkOutput("idle load active", div_active, 7);
    checkOutput("idle load ready", div_ready, 1);
    applyStimulus(1'b1, 1'b0, '0);
    step(1);
    checkOutput("D7 first rise", tick_rise, 1);
    measure(h, p, f);
    checkOutput("D7 high", h, 4);
    checkOutput("D7 period", p, 7);
    checkOutput("D7 fall offset", f, 4);

    // Mid-period reload 10 -> 4 offered at cnt=3
    load_ratio(16'd10);
    wait_rise();
    step(3);
    applyStimulus(1'b1, 1'b1, 16'd4);
    step(1);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("reload ready low", div_ready, 0);
    n = 0; ready_early = 0;
    while (!tick_rise && n < 50) begin
      if (div_ready) ready_early = 1;
      step(1);
      n++;
    end
    checkOutput("reload remaining cycles", n, 6);
    checkOutput("reload ready held low", ready_early, 0);
    checkOutput("reload active at boundary", div_active, 4);
    checkOutput("reload ready at boundary", div_ready, 1);
    measure(h, p, f);
    checkOutput("D4 high", h, 2);
    checkOutput("D4 period", p, 4);

    // Rejected ratios
    applyStimulus(1'b1, 1'b1, 16'd1);
    step(1);
    checkOutput("err div1", div_err, 1);
    checkOutput("err div1 ready", div_ready, 1);
    applyStimulus(1'b1, 1'b1, 16'd0);
    step(1);
    checkOutput("err div0", div_err, 1);
    applyStimulus(1'b1, 1'b0, '0);
    step(1);
    checkOutput("err cleared", div_err, 0);
    checkOutput("err active kept", div_active, 4);
    wait_rise();
    measure(h, p, f);
    checkOutput("err period kept", p, 4);

    // Minimum ratio
    load_ratio(16'd2);
    wait_rise();
    measure(h, p, f);
    checkOutput("D2 high", h, 1);
    checkOutput("D2 period", p, 2);
    checkOutput("D2 fall offset", f, 1);

    // Stop at cnt=2 of D=8
    load_ratio(16'd8);
    wait_rise();
    step(2);
    applyStimulus(1'b0, 1'b0, '0);
    step(2);
    checkOutput("drain clk low cnt4", clk_out, 0);
    checkOutput("drain running cnt4", running, 1);
    step(3);
    checkOutput("drain running cnt7", running, 1);
    step(1);
    checkOutput("drain stopped", running, 0);
    checkOutput("drain clk_out", clk_out, 0);
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (tick_rise || tick_fall) ticks++;
    end
    checkOutput("no ticks after stop", ticks, 0);

    // Async reset mid high phase
    applyStimulus(1'b1, 1'b0, '0);
    step(1);
    checkOutput("restart rise", tick_rise, 1);
    step(1);
    checkOutput("mid high clk_out", clk_out, 1);
    #2 reset = 1'b0;
    #1;
    checkOutput("async clk_out", clk_out, 0);
    checkOutput("async running", running, 0);
    checkOutput("async div_active", div_active, DEF);
    checkOutput("async div_ready", div_ready, 1);
    step(1);
    reset = 1'b1;
    step(1);
    checkOutput("post reset start", tick_rise, 1);
    measure(h, p, f);
    checkOutput("post reset high", h, 25);
    checkOutput("post reset period", p, 50);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
